// File: rtl/m_mem_arbiter.sv
// ============================================================================
// m_mem_arbiter : round-robin I/D arbiter for a single-port 4K x 32 memory
// Revision      : 1.0
// ============================================================================
`default_nettype none

module m_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              w_clk,
   input  logic              w_rst_n,
   input  logic              w_i_req,
   input  logic [ADDR_W-1:0] w_i_addr,
   output logic              w_i_ack,
   output logic [DATA_W-1:0] w_i_rdata,
   input  logic              w_d_req,
   input  logic              w_d_we,
   input  logic [ADDR_W-1:0] w_d_addr,
   input  logic [DATA_W-1:0] w_d_wdata,
   output logic              w_d_ack,
   output logic [DATA_W-1:0] w_d_rdata,
   output logic [ADDR_W-1:0] w_m_addr,
   output logic              w_m_we,
   output logic [DATA_W-1:0] w_m_din,
   input  logic [DATA_W-1:0] w_m_dout,
   output logic [CNT_W-1:0]  w_conflicts
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_d_q, last_d_d;   // 1: D won the last grant
   logic                i_ack_q, i_ack_d;
   logic                d_ack_q, d_ack_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic [CNT_W-1:0]    conflicts_q, conflicts_d;
   logic                elig_i, elig_d;

   // A requester still holding req during its own ack cycle is not eligible.
   assign elig_i = w_i_req & ~i_ack_q;
   assign elig_d = w_d_req & ~d_ack_q;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b1;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         conflicts_q <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         conflicts_q <= conflicts_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      conflicts_d = conflicts_q;
      w_m_addr    = '0;
      w_m_we      = 1'b0;
      w_m_din     = '0;

      case (state_q)
         IDLE: begin
            if (elig_i && elig_d) begin
               if (conflicts_q != {CNT_W{1'b1}})
                  conflicts_d = conflicts_q + CNT_W'(1);
               if (last_d_q) begin
                  state_d  = BUSY_I;
                  last_d_d = 1'b0;
               end else begin
                  state_d  = BUSY_D;
                  last_d_d = 1'b1;
               end
            end else if (elig_i) begin
               state_d  = BUSY_I;
               last_d_d = 1'b0;
            end else if (elig_d) begin
               state_d  = BUSY_D;
               last_d_d = 1'b1;
            end
         end
         BUSY_I: begin
            w_m_addr  = w_i_addr;
            i_rdata_d = w_m_dout;
            i_ack_d   = 1'b1;
            state_d   = IDLE;
         end
         BUSY_D: begin
            // Read data captured here is the pre-write word on a store.
            w_m_addr  = w_d_addr;
            w_m_we    = w_d_we;
            w_m_din   = w_d_wdata;
            d_rdata_d = w_m_dout;
            d_ack_d   = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign w_i_ack     = i_ack_q;
   assign w_d_ack     = d_ack_q;
   assign w_i_rdata   = i_rdata_q;
   assign w_d_rdata   = d_rdata_q;
   assign w_conflicts = conflicts_q;

endmodule

`default_nettype wire

// File: tb/tb_m_mem_arbiter.sv
// ============================================================================
// tb_m_mem_arbiter : directed self-checking bench for m_mem_arbiter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_m_mem_arbiter;

   logic        w_clk;
   logic        w_rst_n;
   logic        w_i_req;
   logic [11:0] w_i_addr;
   logic        w_i_ack;
   logic [31:0] w_i_rdata;
   logic        w_d_req;
   logic        w_d_we;
   logic [11:0] w_d_addr;
   logic [31:0] w_d_wdata;
   logic        w_d_ack;
   logic [31:0] w_d_rdata;
   logic [11:0] w_m_addr;
   logic        w_m_we;
   logic [31:0] w_m_din;
   logic [31:0] w_m_dout;
   logic [15:0] w_conflicts;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory model: async read, synchronous write, plus a bench preload port.
   logic [31:0] mem [0:4095];
   logic        pre_en;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;

   assign w_m_dout = mem[w_m_addr];

   always @(posedge w_clk) begin
      if (pre_en)
         mem[pre_addr] <= pre_data;
      else if (w_m_we)
         mem[w_m_addr] <= w_m_din;
   end

   m_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .CNT_W(16)) dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .w_i_req     (w_i_req),
      .w_i_addr    (w_i_addr),
      .w_i_ack     (w_i_ack),
      .w_i_rdata   (w_i_rdata),
      .w_d_req     (w_d_req),
      .w_d_we      (w_d_we),
      .w_d_addr    (w_d_addr),
      .w_d_wdata   (w_d_wdata),
      .w_d_ack     (w_d_ack),
      .w_d_rdata   (w_d_rdata),
      .w_m_addr    (w_m_addr),
      .w_m_we      (w_m_we),
      .w_m_din     (w_m_din),
      .w_m_dout    (w_m_dout),
      .w_conflicts (w_conflicts)
   );

   initial w_clk = 1'b0;
   always #10 w_clk = ~w_clk;

   task automatic tick;
      @(posedge w_clk);
      #1;
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_en   = 1'b0;
   endtask

   task automatic do_reset;
      w_rst_n = 1'b0;
      tick();
      w_rst_n = 1'b1;
   endtask

   task automatic test_reset;
      w_rst_n  = 1'b0;
      w_i_req  = 1'b1;
      w_i_addr = 12'd1;
      w_d_req  = 1'b1;
      w_d_we   = 1'b1;
      w_d_addr = 12'd3;
      w_d_wdata = 32'h5555_AAAA;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (w_i_ack !== 1'b0 || w_d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_acks: i_ack=%b d_ack=%b required 0 0", w_i_ack, w_d_ack);
         end
         n_checks++;
         if (w_i_rdata !== 32'h0 || w_d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: i=%h d=%h required 0 0", w_i_rdata, w_d_rdata);
         end
         n_checks++;
         if (w_m_we !== 1'b0 || w_conflicts !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_we_cnt: we=%b cnt=%0d required 0 0", w_m_we, w_conflicts);
         end
      end
      w_i_req = 1'b0;
      w_d_req = 1'b0;
      w_d_we  = 1'b0;
      w_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fetch;
      preload(12'd1, 32'h0001_2020);
      w_i_req  = 1'b1;
      w_i_addr = 12'd1;
      tick();  // E0
      n_checks++;
      if (w_i_ack !== 1'b0 || w_m_addr !== 12'd1 || w_m_we !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_e0: ack=%b maddr=%0d we=%b required 0 1 0", w_i_ack, w_m_addr, w_m_we);
      end
      tick();  // E1
      n_checks++;
      if (w_i_ack !== 1'b1 || w_i_rdata !== 32'h0001_2020) begin
         n_fail++;
         $display("FAIL fetch_e1: ack=%b rdata=%h required 1 00012020", w_i_ack, w_i_rdata);
      end
      w_i_req = 1'b0;
      tick();
      n_checks++;
      if (w_i_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_ack_width: ack=%b required 0", w_i_ack);
      end
   endtask

   task automatic test_store_load;
      preload(12'd5, 32'h1111_1111);
      w_d_req   = 1'b1;
      w_d_we    = 1'b1;
      w_d_addr  = 12'd5;
      w_d_wdata = 32'hDEAD_BEEF;
      tick();  // E0
      n_checks++;
      if (w_d_ack !== 1'b0 || w_m_we !== 1'b1 || w_m_din !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL store_e0: ack=%b we=%b din=%h required 0 1 deadbeef", w_d_ack, w_m_we, w_m_din);
      end
      tick();  // E1
      n_checks++;
      if (w_d_ack !== 1'b1 || w_d_rdata !== 32'h1111_1111) begin
         n_fail++;
         $display("FAIL store_e1: ack=%b rdata=%h required 1 11111111", w_d_ack, w_d_rdata);
      end
      n_checks++;
      if (mem[5] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL store_mem: mem5=%h required deadbeef", mem[5]);
      end
      w_d_req = 1'b0;
      w_d_we  = 1'b0;
      tick();
      w_d_req = 1'b1;
      tick();
      tick();
      n_checks++;
      if (w_d_ack !== 1'b1 || w_d_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL load_after_store: ack=%b rdata=%h required 1 deadbeef", w_d_ack, w_d_rdata);
      end
      w_d_req = 1'b0;
      tick();
   endtask

   task automatic test_contention;
      do_reset();
      w_i_req  = 1'b1;
      w_i_addr = 12'd1;
      w_d_req  = 1'b1;
      w_d_we   = 1'b0;
      w_d_addr = 12'd5;
      tick();  // E0
      n_checks++;
      if (w_conflicts !== 16'd1 || w_i_ack !== 1'b0 || w_d_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL cont_e0: cnt=%0d i=%b d=%b required 1 0 0", w_conflicts, w_i_ack, w_d_ack);
      end
      tick();  // E1
      n_checks++;
      if (w_i_ack !== 1'b1 || w_d_ack !== 1'b0 || w_i_rdata !== 32'h0001_2020) begin
         n_fail++;
         $display("FAIL cont_e1: i=%b d=%b rdata=%h required 1 0 00012020", w_i_ack, w_d_ack, w_i_rdata);
      end
      w_i_req = 1'b0;
      tick();  // E2
      tick();  // E3
      n_checks++;
      if (w_d_ack !== 1'b1 || w_d_rdata !== 32'hDEAD_BEEF || w_conflicts !== 16'd1) begin
         n_fail++;
         $display("FAIL cont_e3: d=%b rdata=%h cnt=%0d required 1 deadbeef 1", w_d_ack, w_d_rdata, w_conflicts);
      end
      w_d_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back;
      logic exp_i;
      do_reset();
      w_i_req  = 1'b1;
      w_i_addr = 12'd1;
      w_d_req  = 1'b1;
      w_d_we   = 1'b0;
      w_d_addr = 12'd5;
      for (int k = 0; k < 8; k++) begin
         exp_i = (k % 2 == 0);
         tick();
         n_checks++;
         if (w_i_ack !== 1'b0 || w_d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap[%0d]: i=%b d=%b required 0 0", k, w_i_ack, w_d_ack);
         end
         tick();
         n_checks++;
         if (w_i_ack !== exp_i || w_d_ack !== !exp_i) begin
            n_fail++;
            $display("FAIL b2b_grant[%0d]: i=%b d=%b required %b %b", k, w_i_ack, w_d_ack, exp_i, !exp_i);
         end
      end
      w_i_req = 1'b0;
      w_d_req = 1'b0;
      tick();
      n_checks++;
      if (w_conflicts !== 16'd1) begin
         n_fail++;
         $display("FAIL b2b_conflicts: cnt=%0d required 1", w_conflicts);
      end
   endtask

   task automatic test_reset_mid_busy;
      preload(12'd7, 32'h7777_7777);
      w_d_req   = 1'b1;
      w_d_we    = 1'b1;
      w_d_addr  = 12'd7;
      w_d_wdata = 32'hCAFE_F00D;
      tick();  // E0: BUSY_D
      n_checks++;
      if (w_m_we !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_busy: we=%b required 1", w_m_we);
      end
      #4;
      w_rst_n = 1'b0;
      #1;
      n_checks++;
      if (w_m_we !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_we: we=%b required 0", w_m_we);
      end
      tick();
      n_checks++;
      if (w_d_ack !== 1'b0 || mem[7] !== 32'h7777_7777) begin
         n_fail++;
         $display("FAIL midrst_nowrite: ack=%b mem7=%h required 0 77777777", w_d_ack, mem[7]);
      end
      w_rst_n = 1'b1;
      tick();
      tick();
      n_checks++;
      if (w_d_ack !== 1'b1 || w_d_rdata !== 32'h7777_7777 || mem[7] !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL midrst_reserve: ack=%b rdata=%h mem7=%h required 1 77777777 cafef00d",
                  w_d_ack, w_d_rdata, mem[7]);
      end
      w_d_req = 1'b0;
      w_d_we  = 1'b0;
      tick();
   endtask

   initial begin
      pre_en    = 1'b0;
      pre_addr  = '0;
      pre_data  = '0;
      w_rst_n   = 1'b0;
      w_i_req   = 1'b0;
      w_i_addr  = '0;
      w_d_req   = 1'b0;
      w_d_we    = 1'b0;
      w_d_addr  = '0;
      w_d_wdata = '0;
      test_reset();
      test_fetch();
      test_store_load();
      test_contention();
      test_back_to_back();
      test_reset_mid_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
